unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (1-cycle read latency) between three
//  requesters: instruction fetch (IF), the MEM-stage data port (DM) and the UART
//  program loader (LD). Sits between IFetch/MEM and the RAM. Generates per-port
//  stall, lets the pipeline freeze on contention and routes read data back with
//  a one-cycle valid pulse.
// PARAMETERS
//  ADDR_W      14  word address width of the shared RAM
//  DATA_W      32  data width
//  STARVE_MAX  4   consecutive IF denials (lost to DM) before IF is force-granted
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       fetch read request
//  if_addr    in   ADDR_W  fetch word address
//  if_rdata   out  DATA_W  fetch read data (= mem_rdata)
//  if_valid   out  1       if_rdata valid this cycle
//  if_stall   out  1       if_req present but not granted this cycle
//  dm_req     in   1       data access request
//  dm_we      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  data word address
//  dm_wdata   in   DATA_W  data write value
//  dm_rdata   out  DATA_W  data read value (= mem_rdata)
//  dm_valid   out  1       access granted last cycle completed (read data valid)
//  dm_stall   out  1       dm_req present but not granted this cycle
//  ld_req     in   1       loader write request (write-only port)
//  ld_addr    in   ADDR_W  loader word address
//  ld_wdata   in   DATA_W  loader write value
//  ld_ack     out  1       loader write done (cycle after grant)
//  mem_en     out  1       RAM enable
//  mem_we     out  1       RAM write enable
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data, valid cycle after read issue
//  owner      out  2       port issued last cycle: 0 none, 1 IF, 2 DM, 3 LD
// BEHAVIOUR
//  - Per-cycle grant (combinational from reqs + state): LD > DM > IF, except IF
//    beats DM when starve_cnt == STARVE_MAX. At most one grant per cycle.
//  - mem_* driven combinationally from the winner; no winner -> mem_en=0,
//    mem_we=0, mem_addr/mem_wdata=0.
//  - x_stall = x_req & ~x_grant (combinational). Requester holds req/addr/data
//    stable while stalled; arbiter does not latch them.
//  - owner register <= winner id each edge (0 if none). Drives response path:
//    if_valid = (owner==1); dm_valid = (owner==2); ld_ack = (owner==3).
//    Latency: grant at cycle N -> valid/ack at N+1. dm_valid also pulses for writes.
//  - starve_cnt (width clog2(STARVE_MAX+1)): +1 (saturating) when if_req lost to
//    DM; cleared on IF grant, when if_req=0, or when IF loses to LD.
//  - Forced IF grant stalls DM one cycle; DM wins next cycle if still requesting.
//  - Loader owns RAM every cycle ld_req=1; IF and DM both stall throughout.
//  - Back-to-back grants to same or different ports allowed every cycle.
//  - Reset (any time, incl. read in flight): owner=0, starve_cnt=0 -> if_valid,
//    dm_valid, ld_ack = 0; pending read result discarded. Stalls/mem_* follow
//    inputs combinationally even during reset, but mem_en/mem_we forced 0 while rst=1.
// TESTING
//  - if_req only, addr 0x10, RAM[0x10]=0xDEADBEEF -> mem_en@N, if_valid & if_rdata=DEADBEEF @N+1.
//  - if_req+dm_req(read 0x20) same cycle -> DM granted, if_stall=1, dm_valid@N+1, IF granted N+1 if dm_req drops.
//  - dm_req held 6 cycles with if_req, STARVE_MAX=4 -> DM wins 4 cycles, IF forced on 5th (dm_stall=1), DM 6th.
//  - ld_req writes 0x00..0x03 while if/dm requesting -> 4 ld_acks, if_stall=dm_stall=1 all 4 cycles, readback matches.
//  - dm write 0x30=0x12345678 then IF read 0x30 next cycle -> if_rdata=0x12345678.
//  - rst pulse the cycle after a DM read grant -> dm_valid stays 0, owner=0, starve_cnt=0, normal grants resume.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch, the data port
// and the UART loader; grants one port per cycle and returns a valid/ack one cycle later.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_IF   = 2'd1,
    PORT_DM   = 2'd2,
    PORT_LD   = 2'd3
  } port_e;

  port_e            winner_c;
  port_e            owner_q;
  logic             if_force_c;
  logic [CNT_W-1:0] starve_cnt;

  // Fixed priority LD > DM > IF, with IF promoted over DM once it has starved long enough.
  always_comb begin
    if_force_c = (starve_cnt == CNT_W'(STARVE_MAX));
    winner_c   = PORT_NONE;
    if (ld_req) begin
      winner_c = PORT_LD;
    end else if (dm_req && !(if_req && if_force_c)) begin
      winner_c = PORT_DM;
    end else if (if_req) begin
      winner_c = PORT_IF;
    end
  end

  // RAM command mux; enables are held off while in reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (winner_c)
      PORT_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      PORT_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      PORT_LD: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      default: ;
    endcase
    if (rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign if_stall = if_req & (winner_c != PORT_IF);
  assign dm_stall = dm_req & (winner_c != PORT_DM);

  // Issue tracking and IF starvation counter; only a loss to DM counts as starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= PORT_NONE;
      starve_cnt <= '0;
    end else begin
      owner_q <= winner_c;
      if (if_req && (winner_c == PORT_DM)) begin
        if (!if_force_c) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign owner    = owner_q;
  assign if_valid = (owner_q == PORT_IF);
  assign dm_valid = (owner_q == PORT_DM);
  assign ld_ack   = (owner_q == PORT_LD);
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: table of per-cycle requests with expected winner,
// a small RAM model behind the arbiter, and a response scoreboard.
module tb_unified_mem_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, dm_req, dm_we, ld_req;
  logic [ADDR_W-1:0] if_addr, dm_addr, ld_addr;
  logic [DATA_W-1:0] dm_wdata, ld_wdata;
  logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic              if_valid, if_stall, dm_valid, dm_stall, ld_ack;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        owner;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, 1-cycle read latency
  logic [DATA_W-1:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    ram[8'h10] <= 32'hDEADBEEF;
    ram[8'h11] <= 32'h11110011;
    ram[8'h12] <= 32'h22220012;
    ram[8'h20] <= 32'hCAFE0020;
    ram[8'h21] <= 32'hCAFE0021;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
  end

  typedef struct {
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [1:0]        win;
  } vec_t;

  typedef struct {
    logic [1:0]        win;
    logic              rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  vec_t              vecs[$];
  exp_t              sb[$];
  logic [DATA_W-1:0] shadow [0:255];
  int                n_pass = 0;
  int                n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ir, input logic [ADDR_W-1:0] ia,
                              input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                              input logic [DATA_W-1:0] dd, input logic lr,
                              input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                              input logic [1:0] w);
    vec_t v;
    v.if_req = ir; v.if_addr = ia;
    v.dm_req = dr; v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd;
    v.ld_req = lr; v.ld_addr = la; v.ld_wdata = ld;
    v.win = w;
    return v;
  endfunction

  // One cycle: drive, check the response to last cycle's issue, check this issue, log it
  task automatic apply(input vec_t v, input string tag);
    exp_t              r, e;
    logic [2:0]        vbits;
    logic              we;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ewd;
    @(posedge clk);
    #1;
    if_req = v.if_req; if_addr = v.if_addr;
    dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    ld_req = v.ld_req; ld_addr = v.ld_addr; ld_wdata = v.ld_wdata;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: got empty queue, expected a pending entry", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, " owner"}, 32'(owner), 32'(r.win));
      vbits = (r.win == 2'd1) ? 3'b100 : (r.win == 2'd2) ? 3'b010 :
              (r.win == 2'd3) ? 3'b001 : 3'b000;
      chk({tag, " valid/ack"}, 32'({if_valid, dm_valid, ld_ack}), 32'(vbits));
      if (r.rd && r.win == 2'd1) chk({tag, " if_rdata"}, if_rdata, r.data);
      if (r.rd && r.win == 2'd2) chk({tag, " dm_rdata"}, dm_rdata, r.data);
    end
    e.win = v.win; e.rd = 1'b0; e.data = '0;
    we = 1'b0; ea = '0; ewd = '0;
    case (v.win)
      2'd1: begin
        ea = v.if_addr; e.rd = 1'b1; e.data = shadow[v.if_addr[7:0]];
      end
      2'd2: begin
        ea = v.dm_addr;
        if (v.dm_we) begin
          we = 1'b1; ewd = v.dm_wdata; shadow[v.dm_addr[7:0]] = v.dm_wdata;
        end else begin
          e.rd = 1'b1; e.data = shadow[v.dm_addr[7:0]];
        end
      end
      2'd3: begin
        ea = v.ld_addr; we = 1'b1; ewd = v.ld_wdata; shadow[v.ld_addr[7:0]] = v.ld_wdata;
      end
      default: ;
    endcase
    chk({tag, " if_stall"}, 32'(if_stall), 32'(v.if_req && v.win != 2'd1));
    chk({tag, " dm_stall"}, 32'(dm_stall), 32'(v.dm_req && v.win != 2'd2));
    chk({tag, " mem_en"}, 32'(mem_en), 32'(v.win != 2'd0));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(ea));
    if (we) chk({tag, " mem_wdata"}, mem_wdata, ewd);
    sb.push_back(e);
  endtask

  initial begin
    exp_t z;
    z.win = 2'd0; z.rd = 1'b0; z.data = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    shadow[8'h10] = 32'hDEADBEEF;
    shadow[8'h11] = 32'h11110011;
    shadow[8'h12] = 32'h22220012;
    shadow[8'h20] = 32'hCAFE0020;
    shadow[8'h21] = 32'hCAFE0021;

    //              if  ifa   dm dw dma    dmwd          ld lda   ldwd          win
    vecs.push_back(mk(0, 'h00, 0, 0, 'h00, 32'h0,        0, 'h00, 32'h0,        2'd0));
    vecs.push_back(mk(1, 'h10, 0, 0, 'h00, 32'h0,        0, 'h00, 32'h0,        2'd1));
    vecs.push_back(mk(1, 'h11, 1, 0, 'h20, 32'h0,        0, 'h00, 32'h0,        2'd2));
    vecs.push_back(mk(1, 'h11, 0, 0, 'h00, 32'h0,        0, 'h00, 32'h0,        2'd1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 'h12, 1, 0, 'h20, 32'h0,      0, 'h00, 32'h0,        2'd2));
    vecs.push_back(mk(1, 'h12, 1, 0, 'h20, 32'h0,        0, 'h00, 32'h0,        2'd1));
    vecs.push_back(mk(1, 'h12, 1, 0, 'h21, 32'h0,        0, 'h00, 32'h0,        2'd2));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h21, 32'h0,        0, 'h00, 32'h0,        2'd2));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 'h10, 1, 0, 'h20, 32'h0,      0, 'h00, 32'h0,        2'd2));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 'h10, 1, 0, 'h20, 32'h0,      1, 14'(i), 32'hA0 + 32'(i), 2'd3));
    vecs.push_back(mk(1, 'h11, 1, 0, 'h21, 32'h0,        0, 'h00, 32'h0,        2'd2));
    vecs.push_back(mk(0, 'h00, 1, 1, 'h30, 32'h12345678, 0, 'h00, 32'h0,        2'd2));
    vecs.push_back(mk(1, 'h30, 0, 0, 'h00, 32'h0,        0, 'h00, 32'h0,        2'd1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 14'(i), 0, 0, 'h00, 32'h0,    0, 'h00, 32'h0,        2'd1));
    vecs.push_back(mk(0, 'h00, 1, 0, 'h02, 32'h0,        0, 'h00, 32'h0,        2'd2));
    vecs.push_back(mk(0, 'h00, 0, 0, 'h00, 32'h0,        0, 'h00, 32'h0,        2'd0));

    rst = 1'b1;
    if_req = 1'b1; if_addr = 14'h10;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset owner", 32'(owner), 32'd0);
    chk("reset valid/ack", 32'({if_valid, dm_valid, ld_ack}), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    rst = 1'b0; if_req = 1'b0;
    sb.push_back(z);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset while a DM read is in flight and the starvation counter is at its limit
    for (int i = 0; i < 4; i++)
      apply(mk(1, 'h11, 1, 0, 'h20, 32'h0, 0, 'h00, 32'h0, 2'd2), $sformatf("pre%0d", i));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst owner", 32'(owner), 32'd0);
    chk("rst dm_valid", 32'(dm_valid), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    void'(sb.pop_front());
    sb.push_back(z);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    apply(mk(1, 'h11, 1, 0, 'h21, 32'h0, 0, 'h00, 32'h0, 2'd2), "post0");
    apply(mk(0, 'h00, 0, 0, 'h00, 32'h0, 0, 'h00, 32'h0, 2'd0), "post1");
    apply(mk(0, 'h00, 0, 0, 'h00, 32'h0, 0, 'h00, 32'h0, 2'd0), "post2");
    chk("scoreboard drained", 32'(sb.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
